// File: rtl/adc_fifo_packer_pkg.sv
// adc_fifo_pkg: shared lane/word geometry, packer state encoding and sample sign extension.
package adc_fifo_pkg;
    localparam int LANES  = 4;
    localparam int LANE_W = 16;
    localparam int WORD_W = LANES * LANE_W;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    // Extend a w-bit two's complement value held in the low bits of x to a full lane.
    function automatic logic [LANE_W-1:0] sign_extend(input logic [LANE_W-1:0] x, input int w);
        logic [LANE_W-1:0] m;
        m = {LANE_W{1'b1}} << w;
        return x[4'(w - 1)] ? (x | m) : (x & ~m);
    endfunction
endpackage

// File: rtl/adc_fifo_packer_if.sv
// adc_fifo_packer_if: sample input and FIFO write port bundle; master feeds samples and models the FIFO, slave is the packer.
interface adc_fifo_packer_if #(parameter int SAMPLE_W = 14);
    import adc_fifo_pkg::*;
    logic                enable;
    logic                in_valid;
    logic [SAMPLE_W-1:0] in_data;
    logic                fifo_full;
    logic                fifo_wren;
    logic [WORD_W-1:0]   fifo_wdata;

    modport master (output enable, in_valid, in_data, fifo_full, input fifo_wren, fifo_wdata);
    modport slave  (input enable, in_valid, in_data, fifo_full, output fifo_wren, fifo_wdata);
endinterface

// File: rtl/adc_fifo_packer_sat_counter.sv
// sat_counter: up counter that sticks at all-ones, with a clear that wins over a simultaneous increment.
module sat_counter #(parameter int CNT_W = 16) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;

    // Count increments until saturated; clear has priority.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) cnt_q <= '0;
        else cnt_q <= clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/adc_fifo_packer.sv
// adc_fifo_packer: packs four sign-extended ADC samples per 64-bit FIFO word, drops words on FIFO full,
// flushes zero-padded partial words when capture stops. Optional ramp source under PACKER_TEST_PATTERN_EN.
module adc_fifo_packer
    import adc_fifo_pkg::*;
#(
    parameter int SAMPLE_W = 14,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstn,
`ifdef PACKER_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    adc_fifo_packer_if.slave bus,
    input  logic             ovf_clr,
    output logic             ovf,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             busy
);
    state_e            state_q;
    logic [1:0]        lane_q;
    logic [WORD_W-1:0] pack_q;
    logic              wren_q;
    logic [WORD_W-1:0] wdata_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic              ovf_q;
    logic [LANE_W-1:0] sample_d;
    logic [WORD_W-1:0] word_d;
    logic              accept_d;
    logic              done_d;
    logic              write_d;
    logic              drop_d;

`ifdef PACKER_TEST_PATTERN_EN
    logic [LANE_W-1:0] ramp_q;
    assign sample_d = test_mode ? ramp_q : sign_extend(LANE_W'(bus.in_data), SAMPLE_W);
`else
    assign sample_d = sign_extend(LANE_W'(bus.in_data), SAMPLE_W);
`endif

    // Lanes above the current index are always zero, so OR-ing in the new lane is enough
    // and a flushed partial word is already zero-padded.
    assign accept_d = state_q == RUN && bus.enable && bus.in_valid;
    assign word_d   = pack_q | (WORD_W'(sample_d) << (LANE_W * lane_q));
    assign done_d   = (accept_d && lane_q == 2'(LANES - 1)) || state_q == FLUSH;
    assign write_d  = done_d && !bus.fifo_full;
    assign drop_d   = done_d && bus.fifo_full;

    // Capture FSM with packing register, registered FIFO write port and written-word counter.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            pack_q     <= '0;
            wren_q     <= 1'b0;
            wdata_q    <= '0;
            word_cnt_q <= '0;
`ifdef PACKER_TEST_PATTERN_EN
            ramp_q     <= '0;
`endif
        end else begin
            wren_q <= write_d;
            if (write_d) begin
                wdata_q    <= state_q == FLUSH ? pack_q : word_d;
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            case (state_q)
                IDLE: if (bus.enable) begin
                    state_q    <= RUN;
                    lane_q     <= '0;
                    pack_q     <= '0;
                    word_cnt_q <= '0;
`ifdef PACKER_TEST_PATTERN_EN
                    ramp_q     <= '0;
`endif
                end
                RUN: begin
                    if (accept_d) begin
                        lane_q <= lane_q + 2'd1;
                        pack_q <= done_d ? '0 : word_d;
`ifdef PACKER_TEST_PATTERN_EN
                        ramp_q <= ramp_q + 1'b1;
`endif
                    end
                    if (!bus.enable) state_q <= lane_q != '0 ? FLUSH : IDLE;
                end
                FLUSH: begin
                    state_q <= IDLE;
                    lane_q  <= '0;
                    pack_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end

    // Sticky overflow; a clear in the same cycle as a drop wins.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) ovf_q <= 1'b0;
        else ovf_q <= ovf_clr ? 1'b0 : drop_d ? 1'b1 : ovf_q;

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc_i (drop_d),
        .clr_i (ovf_clr),
        .cnt_o (drop_cnt)
    );

    assign bus.fifo_wren  = wren_q;
    assign bus.fifo_wdata = wdata_q;
    assign ovf            = ovf_q;
    assign word_cnt       = word_cnt_q;
    assign busy           = state_q != IDLE;
endmodule
